// File: rtl/main_scu_bac_coalesce_interrupt_handle.sv
// main_scu_bac_coalesce_interrupt_handle
// SCU interrupt aggregator. Each source has an enable bit and a status bit,
// and can be detected on level or on rising edge. The block reports the
// number of pending enabled sources. A three-state coalescing FSM uses a
// count threshold and a timeout to drive a single registered interrupt line.
// Optional build macro: MAIN_SCU_BAC_INT_SYNC_EN. When it is defined, int_hw_i
// goes through a 2-flop synchronizer before edge detection.
module main_scu_bac_coalesce_interrupt_handle #(
    parameter int p_int_num = 32,
    parameter int p_thr_w   = 7,
    parameter int p_tmr_w   = 16
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic [p_int_num-1:0] int_hw_i,
    input  logic [p_int_num-1:0] int_mode_i,
    input  logic [p_int_num-1:0] int_enable_set_i,
    input  logic [p_int_num-1:0] int_enable_clr_i,
    input  logic [p_int_num-1:0] int_sw_set_i,
    input  logic [p_int_num-1:0] int_sw_clr_i,
    input  logic [p_thr_w-1:0]   coal_thresh_i,
    input  logic [p_tmr_w-1:0]   coal_timeout_i,
    output logic [p_int_num-1:0] int_enable_status_o,
    output logic [p_int_num-1:0] int_status_o,
    output logic [p_int_num-1:0] enabled_int_status_o,
    output logic [p_thr_w-1:0]   pending_cnt_o,
    output logic                 interrupt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ASSERT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [p_tmr_w-1:0]   timer_q, timer_d;
    logic [p_int_num-1:0] hw_src;
    logic [p_int_num-1:0] prev_q;
    logic [p_int_num-1:0] hw_set;
    logic [p_thr_w-1:0]   eff_thr;
    logic                 timeout_hit;

`ifdef MAIN_SCU_BAC_INT_SYNC_EN
    logic [p_int_num-1:0] sync_q1, sync_q2;

    // Two-flop synchronizer for asynchronous hardware sources
    always_ff @(posedge clk_i) begin
        // NOTE: use non-blocking (<=) for every flop, so that all registers sample pre-edge values.
        if (!resetn_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= int_hw_i;
            sync_q2 <= sync_q1;
        end
    end

    assign hw_src = sync_q2;
`else
    assign hw_src = int_hw_i;
`endif

    // Edge history. Reset to 0, so a source that is already high counts as an edge.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) prev_q <= '0;
        else           prev_q <= hw_src;
    end

    assign hw_set = (int_mode_i & hw_src & ~prev_q) | (~int_mode_i & hw_src);

    // Enable register: set wins over clear
    always_ff @(posedge clk_i) begin
        if (!resetn_i) int_enable_status_o <= '0;
        else           int_enable_status_o <= int_enable_set_i
                                            | (int_enable_status_o & ~int_enable_clr_i);
    end

    // Status register: hardware set, then software set, then software clear
    always_ff @(posedge clk_i) begin
        if (!resetn_i) int_status_o <= '0;
        else           int_status_o <= hw_set | int_sw_set_i
                                     | (int_status_o & ~int_sw_clr_i);
    end

    assign enabled_int_status_o = int_status_o & int_enable_status_o;

    // Popcount of the enabled pending bits. The width rule guarantees it cannot overflow.
    always_comb begin
        // NOTE: assign a default before the loop, so that no path through the block leaves the output unassigned (latch).
        pending_cnt_o = '0;
        for (int i = 0; i < p_int_num; i++) begin
            pending_cnt_o = pending_cnt_o + p_thr_w'(enabled_int_status_o[i]);
        end
    end

    assign eff_thr     = (coal_thresh_i == '0) ? p_thr_w'(1) : coal_thresh_i;
    assign timeout_hit = (coal_timeout_i != '0)
                      && (timer_q >= (coal_timeout_i - p_tmr_w'(1)));

    // Coalescing next-state and timer logic
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        unique case (state_q)
            IDLE: begin
                if (pending_cnt_o >= eff_thr)     state_d = ASSERT;
                else if (pending_cnt_o != '0)     state_d = COLLECT;
            end
            COLLECT: begin
                if (pending_cnt_o == '0)          state_d = IDLE;
                else if (pending_cnt_o >= eff_thr) state_d = ASSERT;
                else if (timeout_hit)             state_d = ASSERT;
                if (state_d == COLLECT) begin
                    timer_d = (timer_q == '1) ? timer_q : timer_q + p_tmr_w'(1);
                end
            end
            ASSERT: begin
                if (pending_cnt_o == '0)          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, timer and registered interrupt line
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            interrupt_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            interrupt_o <= (state_d == ASSERT);
        end
    end

endmodule

// File: tb/tb_main_scu_bac_coalesce_interrupt_handle.sv
// Directed scoreboard bench for main_scu_bac_coalesce_interrupt_handle.
// Expected values are pushed when stimulus is applied and popped at the sample point.
module tb_main_scu_bac_coalesce_interrupt_handle;

    localparam int N   = 32;
    localparam int THW = 7;
    localparam int TMW = 16;
`ifdef MAIN_SCU_BAC_INT_SYNC_EN
    localparam int HW_X = 2;
`else
    localparam int HW_X = 0;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   hw, mode, en_set, en_clr, sw_set, sw_clr;
    logic [THW-1:0] thresh;
    logic [TMW-1:0] tmo;
    logic [N-1:0]   en_st, st, en_int;
    logic [THW-1:0] pcnt;
    logic           irq;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    main_scu_bac_coalesce_interrupt_handle #(
        .p_int_num(N), .p_thr_w(THW), .p_tmr_w(TMW)
    ) dut (
        .clk_i                (clk),
        .resetn_i             (resetn),
        .int_hw_i             (hw),
        .int_mode_i           (mode),
        .int_enable_set_i     (en_set),
        .int_enable_clr_i     (en_clr),
        .int_sw_set_i         (sw_set),
        .int_sw_clr_i         (sw_clr),
        .coal_thresh_i        (thresh),
        .coal_timeout_i       (tmo),
        .int_enable_status_o  (en_st),
        .int_status_o         (st),
        .enabled_int_status_o (en_int),
        .pending_cnt_o        (pcnt),
        .interrupt_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        hw = '0; mode = '0; en_set = '0; en_clr = '0; sw_set = '0; sw_clr = '0;
        thresh = '0; tmo = '0;
        tick(); tick();
        // reset state
        sb_push("rst_en", 64'h0);  sb_check(64'(en_st));
        sb_push("rst_st", 64'h0);  sb_check(64'(st));
        sb_push("rst_cnt", 64'h0); sb_check(64'(pcnt));
        sb_push("rst_irq", 64'h0); sb_check(64'(irq));
        resetn = 1'b1;
        tick();

        // 1: level pulse on bit0, threshold 0 acts as 1
        en_set[0] = 1'b1; tick(); en_set = '0;
        sb_push("s1_en", 64'h1); sb_check(64'(en_st));
        hw[0] = 1'b1; tick(); hw = '0;
        repeat (HW_X) tick();
        sb_push("s1_st", 64'h1);      sb_check(64'(st));
        sb_push("s1_irq_lo", 64'h0);  sb_check(64'(irq));
        tick();
        sb_push("s1_irq_hi", 64'h1);  sb_check(64'(irq));
        sb_push("s1_cnt", 64'h1);     sb_check(64'(pcnt));
        sw_clr[0] = 1'b1; tick(); sw_clr = '0;
        sb_push("s1_st_clr", 64'h0);  sb_check(64'(st));
        sb_push("s1_irq_hold", 64'h1); sb_check(64'(irq));
        tick();
        sb_push("s1_irq_off", 64'h0); sb_check(64'(irq));
        // software path latency is two cycles in either build
        sw_set[0] = 1'b1; tick(); sw_set = '0;
        sb_push("s1_sw_lo", 64'h0); sb_check(64'(irq));
        tick();
        sb_push("s1_sw_hi", 64'h1); sb_check(64'(irq));
        sw_clr[0] = 1'b1; tick(); sw_clr = '0; tick();

        // 2: bit3 edge mode, held high, one clear sticks
        mode[3] = 1'b1; hw[3] = 1'b1;
        repeat (4) tick();
        sb_push("s2e_set", 64'h1); sb_check(64'(st[3]));
        sw_clr[3] = 1'b1; tick(); sw_clr = '0;
        sb_push("s2e_clr", 64'h0); sb_check(64'(st[3]));
        repeat (5) tick();
        sb_push("s2e_stay", 64'h0); sb_check(64'(st[3]));
        hw[3] = 1'b0; repeat (HW_X + 2) tick();
        // bit3 in level mode: clear has no effect while high
        mode[3] = 1'b0; hw[3] = 1'b1;
        repeat (4) tick();
        sw_clr[3] = 1'b1; tick(); sw_clr = '0;
        sb_push("s2l_clr", 64'h1); sb_check(64'(st[3]));
        repeat (5) tick();
        sb_push("s2l_stay", 64'h1); sb_check(64'(st[3]));
        hw[3] = 1'b0; repeat (HW_X + 1) tick();
        sw_clr[3] = 1'b1; tick(); sw_clr = '0;
        sb_push("s2l_off", 64'h0); sb_check(64'(st[3]));

        // 3: threshold 4, all enabled
        en_set = '1; tick(); en_set = '0;
        thresh = 7'd4;
        sw_set = 32'h0000_0007; tick(); sw_set = '0;
        sb_push("s3_cnt3", 64'd3); sb_check(64'(pcnt));
        sb_push("s3_irq0", 64'h0); sb_check(64'(irq));
        tick();
        sb_push("s3_coll", 64'h0); sb_check(64'(irq));
        sw_set[5] = 1'b1; tick(); sw_set = '0;
        sb_push("s3_cnt4", 64'd4); sb_check(64'(pcnt));
        sb_push("s3_irq_lo", 64'h0); sb_check(64'(irq));
        tick();
        sb_push("s3_irq_hi", 64'h1); sb_check(64'(irq));
        sw_clr = '1; tick(); sw_clr = '0; tick();
        sb_push("s3_irq_off", 64'h0); sb_check(64'(irq));

        // 4: timeout 20 with one pending source
        thresh = 7'd8; tmo = 16'd20;
        sw_set[2] = 1'b1; tick(); sw_set = '0;
        repeat (20) tick();
        sb_push("s4_pre_to", 64'h0); sb_check(64'(irq));
        tick();
        sb_push("s4_to", 64'h1); sb_check(64'(irq));
        sw_clr[2] = 1'b1; tick(); sw_clr = '0; tick();
        sb_push("s4_off", 64'h0); sb_check(64'(irq));
        // clear mid-COLLECT: back to IDLE, no interrupt
        sw_set[2] = 1'b1; tick(); sw_set = '0;
        repeat (10) tick();
        sw_clr[2] = 1'b1; tick(); sw_clr = '0;
        sb_push("s4_cnt0", 64'h0); sb_check(64'(pcnt));
        repeat (20) tick();
        sb_push("s4_abort", 64'h0); sb_check(64'(irq));
        // lowering the threshold mid-COLLECT asserts on the next edge
        sw_set[2] = 1'b1; tick(); sw_set = '0;
        tick(); tick();
        sb_push("s4_lower_pre", 64'h0); sb_check(64'(irq));
        thresh = 7'd1; tick();
        sb_push("s4_lower", 64'h1); sb_check(64'(irq));
        sw_clr[2] = 1'b1; tick(); sw_clr = '0; tick();
        thresh = '0; tmo = '0;

        // 5: status on a disabled bit, then enable it, then reset in ASSERT
        en_clr = '1; tick(); en_clr = '0;
        sw_set[9] = 1'b1; tick(); sw_set = '0;
        sb_push("s5_st", 64'h200);  sb_check(64'(st));
        sb_push("s5_en_int", 64'h0); sb_check(64'(en_int));
        tick();
        sb_push("s5_irq0", 64'h0); sb_check(64'(irq));
        en_set[9] = 1'b1; tick(); en_set = '0;
        sb_push("s5_en_int1", 64'h200); sb_check(64'(en_int));
        sb_push("s5_irq_lo", 64'h0);    sb_check(64'(irq));
        tick();
        sb_push("s5_irq_hi", 64'h1); sb_check(64'(irq));
        resetn = 1'b0; tick(); resetn = 1'b1;
        sb_push("s5_rst_st", 64'h0);  sb_check(64'(st));
        sb_push("s5_rst_en", 64'h0);  sb_check(64'(en_st));
        sb_push("s5_rst_irq", 64'h0); sb_check(64'(irq));
        sb_push("s5_rst_cnt", 64'h0); sb_check(64'(pcnt));

        // boundaries: enable_set with sw_clr on one bit; all bits pending; disable in ASSERT
        sw_set[4] = 1'b1; tick(); sw_set = '0;
        en_set[4] = 1'b1; sw_clr[4] = 1'b1; tick(); en_set = '0; sw_clr = '0;
        sb_push("b_en4", 64'h1); sb_check(64'(en_st[4]));
        sb_push("b_st4", 64'h0); sb_check(64'(st[4]));
        en_set = '1; sw_set = '1; tick(); en_set = '0; sw_set = '0;
        sb_push("b_all", 64'd32); sb_check(64'(pcnt));
        tick();
        sb_push("b_all_irq", 64'h1); sb_check(64'(irq));
        en_clr = '1; tick(); en_clr = '0;
        sb_push("b_dis_cnt", 64'h0); sb_check(64'(pcnt));
        tick();
        sb_push("b_dis_irq", 64'h0); sb_check(64'(irq));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_scu_bac_coalesce_interrupt_handle.md
Name: main_scu_bac_coalesce_interrupt_handle

Overview:
Next-generation SCU interrupt aggregator for p_int_num sources.
- Per-source enable and status registers, as in the existing handlers.
- Adds per-source level/rising-edge detection, a pending-count output, and an interrupt-coalescing FSM (count threshold plus timeout) driving one registered interrupt line.
- Sits between SCU hardware event sources / register-interface set-clear strobes and the CPU interrupt controller.

Parameters:
p_int_num, 32, number of interrupt sources (1..64)
p_thr_w, 7, width of coalescing threshold input; must satisfy 2^p_thr_w > p_int_num
p_tmr_w, 16, width of coalescing timeout input and internal timer

Ports:
clk_i  input  1  clock
resetn_i  input  1  synchronous active-low reset
int_hw_i  input  p_int_num  raw hardware interrupt sources
int_mode_i  input  p_int_num  per-source mode, quasi-static: 0=level, 1=rising edge
int_enable_set_i  input  p_int_num  enable set strobes
int_enable_clr_i  input  p_int_num  enable clear strobes
int_sw_set_i  input  p_int_num  software status set strobes
int_sw_clr_i  input  p_int_num  software status clear strobes
coal_thresh_i  input  p_thr_w  pending-count threshold; 0 treated as 1
coal_timeout_i  input  p_tmr_w  coalescing timeout in cycles; 0 = timeout disabled
int_enable_status_o  output  p_int_num  enable register
int_status_o  output  p_int_num  raw status register
enabled_int_status_o  output  p_int_num  int_status_o & int_enable_status_o
pending_cnt_o  output  p_thr_w  popcount of enabled_int_status_o
interrupt_o  output  1  registered aggregated interrupt

Behaviour:
Reset:
- All registers take their reset value on a clk_i edge with resetn_i low; reset has priority over every other input.
- Registers cleared: enable, status, edge-history (prev) register, timer, interrupt_o.
- FSM returns to IDLE.
- Reset mid-COLLECT or mid-ASSERT aborts without glitching interrupt_o high.

Edge detection:
- prev[i] <= int_hw_i[i] every cycle.
- hw_set[i] = int_mode_i[i] ? (int_hw_i[i] & ~prev[i]) : int_hw_i[i].
- prev resets to 0, so a source already high on the first cycle after reset counts as an edge.

Enable register:
- Per bit: set > clr > hold.

Status register:
- Per bit: hw_set > sw_set > sw_clr > hold.
- A level-mode source held high re-sets status every cycle, so sw_clr has no effect while it stays high.
- Status updates regardless of enable; enable only gates the enabled and aggregated outputs.

Combinational outputs:
- enabled_int_status_o and pending_cnt_o are combinational from the registers.
- pending_cnt_o is zero-extended to p_thr_w.
- eff_thr = (coal_thresh_i==0) ? 1 : coal_thresh_i.

Coalescing FSM, states IDLE / COLLECT / ASSERT:
IDLE:
- timer=0.
- If pending_cnt_o >= eff_thr -> ASSERT.
- Else if pending_cnt_o != 0 -> COLLECT.
COLLECT:
- timer increments by 1 per cycle, saturating at all-ones.
- If pending_cnt_o == 0 -> IDLE; this check has priority.
- Else if pending_cnt_o >= eff_thr -> ASSERT.
- Else if coal_timeout_i != 0 and timer >= coal_timeout_i-1 -> ASSERT.
ASSERT:
- Remains in ASSERT while pending_cnt_o != 0.
- pending_cnt_o == 0 -> IDLE, with timer cleared.

interrupt_o:
- interrupt_o <= (next_state == ASSERT).
- Latency with eff_thr=1: hw event sampled at edge t -> status at t+1 -> interrupt_o high after edge t+2.
- Deasserts one cycle after the last enabled status bit clears.

Configuration changes:
- Changes to coal_thresh_i or coal_timeout_i take effect the next cycle, including mid-COLLECT.
- Lowering the threshold below the current count causes ASSERT.

Boundary conditions:
- All p_int_num bits pending: pending_cnt_o = p_int_num, with no overflow by the width rule.
- Simultaneous enable_set and sw_clr on the same bit: both apply, so that bit is enabled and its status cleared.
- Disabling the last pending source while in ASSERT or COLLECT -> IDLE.

Optional Feature:
Macro: MAIN_SCU_BAC_INT_SYNC_EN
- Defined: int_hw_i passes through a 2-flop synchronizer (reset value 0) before edge detection. Adds 2 cycles to hw-path latency (interrupt_o after edge t+4); the sw paths are unchanged.
- Undefined: int_hw_i is used directly, with the latency stated above.

Test Plan:
1. Reset, then enable bit0 (level mode), thresh=0, timeout=0, and pulse int_hw_i[0] high for 1 cycle at edge t -> int_status_o[0]=1 at t+1, interrupt_o=1 after t+2; sw_clr[0] -> interrupt_o=0 one cycle after status clears.
2. Bit3 in edge mode with int_hw_i[3] held high 10 cycles and sw_clr[3] at cycle 4 -> status clears and stays 0 (only one edge); bit3 in level mode with the same stimulus -> status stays 1.
3. All 32 bits enabled, thresh=4, timeout=0; raise sources 0,1,2 -> FSM in COLLECT, interrupt_o=0; raise source 5 -> pending_cnt_o=4, interrupt_o=1 two cycles later.
4. thresh=8, timeout=20, one enabled pending source -> interrupt_o rises exactly 20 cycles after COLLECT entry (+1 register stage); clear the source at cycle 10 of a new COLLECT -> IDLE, no interrupt.
5. Status set on a disabled bit -> int_status_o=1, enabled_int_status_o=0, interrupt_o=0; enable_set -> interrupt_o=1 two cycles later; resetn_i low for one cycle while in ASSERT -> all outputs 0 after that edge.
6. With MAIN_SCU_BAC_INT_SYNC_EN defined, repeat scenario 1 -> interrupt_o after edge t+4; sw_set path latency unchanged (2 cycles).
